// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port framebuffer BRAM between the display
// line fetcher (fixed priority) and the CPU bus. A saturating wait counter
// bounds how long a pending CPU request can be refused. Read data is steered
// back to the right requester by a tag pipeline matched to the BRAM latency.
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int RD_LATENCY   = 1,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      disp_req_valid,
    output logic                      disp_req_ready,
    input  logic [ADDR_WIDTH-1:0]     disp_req_addr,
    output logic                      disp_rsp_valid,
    output logic [DATA_WIDTH-1:0]     disp_rsp_data,

    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic                      cpu_req_write,
    input  logic [ADDR_WIDTH-1:0]     cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]     cpu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cpu_req_wstrb,
    output logic                      cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0]     cpu_rsp_data,

    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    // Tag bit positions: display read, CPU access, CPU access was a write.
    localparam int T_DISP = 0;
    localparam int T_CPU  = 1;
    localparam int T_WR   = 2;

    logic [WAIT_W-1:0] wait_cnt;
    logic              force_cpu;
    logic              grant_cpu;
    logic              grant_disp;
    logic [2:0]        tag_pipe [RD_LATENCY];
    logic [2:0]        tag_out;

    // Grant: display wins unless the CPU has waited its maximum.
    always_comb begin
        force_cpu  = cpu_req_valid && (wait_cnt == WAIT_MAX);
        grant_cpu  = !reset && cpu_req_valid && (force_cpu || !disp_req_valid);
        grant_disp = !reset && disp_req_valid && !grant_cpu;
        disp_req_ready = grant_disp;
        cpu_req_ready  = grant_cpu;
    end

    // BRAM port drive from the winning requester.
    always_comb begin
        mem_en    = grant_disp || grant_cpu;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_addr  = cpu_req_addr;
            mem_wdata = cpu_req_wdata;
            if (cpu_req_write) begin
                mem_we = cpu_req_wstrb;
            end
        end else if (grant_disp) begin
            mem_addr = disp_req_addr;
        end
    end

    // CPU starvation counter: counts refused cycles, saturates at the limit.
    always_ff @(posedge clock) begin
        if (reset || !cpu_req_valid || grant_cpu) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Tag shift register; depth equals BRAM read latency, flushed on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= {grant_cpu && cpu_req_write, grant_cpu, grant_disp};
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Response steering; outputs are held quiet while reset is asserted so a
    // tag registered just before reset cannot leak a response.
    always_comb begin
        tag_out        = tag_pipe[RD_LATENCY-1];
        disp_rsp_valid = !reset && tag_out[T_DISP];
        cpu_rsp_valid  = !reset && tag_out[T_CPU];
        disp_rsp_data  = disp_rsp_valid ? mem_rdata : '0;
        cpu_rsp_data   = (cpu_rsp_valid && !tag_out[T_WR]) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: two instances (read latency 1 and 2) share one
// stimulus stream; each drives its own BRAM model. Expected grants come from
// the vector records, expected responses from a scoreboard fed by a reference
// memory at accept time.
module tb_vram_arbiter;

    logic        clock;
    logic        reset;
    logic        disp_req_valid;
    logic [14:0] disp_req_addr;
    logic        cpu_req_valid;
    logic        cpu_req_write;
    logic [14:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic [3:0]  cpu_req_wstrb;

    logic        d1_dr, d1_cr, d1_dv, d1_cv, d1_en;
    logic [31:0] d1_dd, d1_cd, d1_wdata, d1_rdata;
    logic [3:0]  d1_we;
    logic [14:0] d1_addr;

    logic        d2_dr, d2_cr, d2_dv, d2_cv, d2_en;
    logic [31:0] d2_dd, d2_cd, d2_wdata, d2_rdata;
    logic [3:0]  d2_we;
    logic [14:0] d2_addr;

    vram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .RD_LATENCY(1), .CPU_MAX_WAIT(8)) dut (
        .clock(clock), .reset(reset),
        .disp_req_valid(disp_req_valid), .disp_req_ready(d1_dr), .disp_req_addr(disp_req_addr),
        .disp_rsp_valid(d1_dv), .disp_rsp_data(d1_dd),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(d1_cr), .cpu_req_write(cpu_req_write),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_rsp_valid(d1_cv), .cpu_rsp_data(d1_cd),
        .mem_en(d1_en), .mem_we(d1_we), .mem_addr(d1_addr), .mem_wdata(d1_wdata), .mem_rdata(d1_rdata)
    );

    vram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .RD_LATENCY(2), .CPU_MAX_WAIT(8)) dut2 (
        .clock(clock), .reset(reset),
        .disp_req_valid(disp_req_valid), .disp_req_ready(d2_dr), .disp_req_addr(disp_req_addr),
        .disp_rsp_valid(d2_dv), .disp_rsp_data(d2_dd),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(d2_cr), .cpu_req_write(cpu_req_write),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_rsp_valid(d2_cv), .cpu_rsp_data(d2_cd),
        .mem_en(d2_en), .mem_we(d2_we), .mem_addr(d2_addr), .mem_wdata(d2_wdata), .mem_rdata(d2_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- memory helpers ----------------
    function automatic logic [31:0] init_word(input int a);
        return 32'hA5A5_0000 ^ 32'(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // BRAM models (read-first), one per instance.
    logic [31:0] bram1 [int];
    logic [31:0] bram2 [int];
    logic [31:0] rd2a;

    initial begin
        d1_rdata = '0;
        d2_rdata = '0;
        rd2a     = '0;
    end

    always @(posedge clock) begin
        logic [31:0] old;
        if (d1_en) begin
            old = bram1.exists(int'(d1_addr)) ? bram1[int'(d1_addr)] : init_word(int'(d1_addr));
            if (d1_we != 4'h0) bram1[int'(d1_addr)] = merge(old, d1_wdata, d1_we);
            d1_rdata <= old;
        end
    end

    always @(posedge clock) begin
        logic [31:0] old;
        if (d2_en) begin
            old = bram2.exists(int'(d2_addr)) ? bram2[int'(d2_addr)] : init_word(int'(d2_addr));
            if (d2_we != 4'h0) bram2[int'(d2_addr)] = merge(old, d2_wdata, d2_we);
            rd2a <= old;
        end
        d2_rdata <= rd2a;
    end

    // Reference memory seen by the scoreboard.
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        bit          r;
        bit          dv;
        logic [14:0] da;
        bit          cv;
        bit          cw;
        logic [14:0] ca;
        logic [31:0] wd;
        logic [3:0]  ws;
        bit          edr;
        bit          ecr;
    } vec_t;

    typedef struct {
        int          due;
        bit          d;
        bit          c;
        logic [31:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc;
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(input bit r, input bit dv, input int da, input bit cv,
                                input bit cw, input int ca, input int wd, input int ws,
                                input bit edr, input bit ecr);
        vec_t v;
        v.r = r; v.dv = dv; v.da = 15'(da); v.cv = cv; v.cw = cw; v.ca = 15'(ca);
        v.wd = 32'(wd); v.ws = 4'(ws); v.edr = edr; v.ecr = ecr;
        return v;
    endfunction

    task automatic chk(input string name, input string what,
                       input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s cyc=%0d actual=%h required=%h", name, what, cyc, act, exp);
        end
    endtask

    task automatic rsp_chk(input string name, input string what, input bit has, input exp_t e,
                           input logic dvl, input logic cvl,
                           input logic [31:0] dd, input logic [31:0] cd);
        logic [65:0] want;
        want = '0;
        if (has) want = {e.d, e.c, (e.d ? e.data : 32'h0), (e.c ? e.data : 32'h0)};
        chk(name, what, 128'({dvl, cvl, dd, cd}), 128'(want));
    endtask

    task automatic do_cycle(input vec_t v, input string name);
        exp_t        e1, e2, ne;
        bit          h1, h2;
        logic [51:0] mexp;
        reset          = v.r;
        disp_req_valid = v.dv;
        disp_req_addr  = v.da;
        cpu_req_valid  = v.cv;
        cpu_req_write  = v.cw;
        cpu_req_addr   = v.ca;
        cpu_req_wdata  = v.wd;
        cpu_req_wstrb  = v.ws;
        @(negedge clock);

        chk(name, "rdy", 128'({d1_dr, d1_cr, d2_dr, d2_cr}), 128'({v.edr, v.ecr, v.edr, v.ecr}));
        mexp = {(v.edr || v.ecr),
                ((v.ecr && v.cw) ? v.ws : 4'h0),
                (v.ecr ? v.ca : (v.edr ? v.da : 15'h0)),
                (v.ecr ? v.wd : 32'h0)};
        chk(name, "mem1", 128'({d1_en, d1_we, d1_addr, d1_wdata}), 128'(mexp));
        chk(name, "mem2", 128'({d2_en, d2_we, d2_addr, d2_wdata}), 128'(mexp));

        // Reset drops everything accepted earlier.
        if (v.r) begin
            q1.delete();
            q2.delete();
        end
        h1 = (q1.size() > 0) && (q1[0].due == cyc);
        h2 = (q2.size() > 0) && (q2[0].due == cyc);
        e1 = '{0, 1'b0, 1'b0, 32'h0};
        e2 = '{0, 1'b0, 1'b0, 32'h0};
        if (h1) e1 = q1.pop_front();
        if (h2) e2 = q2.pop_front();
        rsp_chk(name, "rsp1", h1, e1, d1_dv, d1_cv, d1_dd, d1_cd);
        rsp_chk(name, "rsp2", h2, e2, d2_dv, d2_cv, d2_dd, d2_cd);

        if (v.edr || v.ecr) begin
            ne.d = v.edr;
            ne.c = v.ecr;
            if (v.edr)      ne.data = ref_rd(int'(v.da));
            else if (v.cw)  ne.data = 32'h0;
            else            ne.data = ref_rd(int'(v.ca));
            ne.due = cyc + 1;
            q1.push_back(ne);
            ne.due = cyc + 2;
            q2.push_back(ne);
            if (v.ecr && v.cw) ref_mem[int'(v.ca)] = merge(ref_rd(int'(v.ca)), v.wd, v.ws);
        end

        @(posedge clock);
        #1;
        cyc++;
    endtask

    vec_t tbl [23];

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        reset = 1'b1;
        disp_req_valid = 1'b0; disp_req_addr = '0;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0;
        cpu_req_wdata = '0; cpu_req_wstrb = '0;

        //           r  dv da      cv cw ca      wd           ws   edr ecr
        tbl[0]  = mk(1, 1, 'h5,   1, 0, 'h6,   0,           0,   0, 0);
        tbl[1]  = mk(1, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[2]  = mk(0, 1, 'h10,  0, 0, 0,     0,           0,   1, 0);
        tbl[3]  = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[4]  = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[5]  = mk(0, 0, 0,     1, 1, 'h20,  0,           'hF, 0, 1);
        tbl[6]  = mk(0, 0, 0,     1, 1, 'h20,  'h12345678,  'h3, 0, 1);
        tbl[7]  = mk(0, 0, 0,     1, 0, 'h20,  0,           0,   0, 1);
        tbl[8]  = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[9]  = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[10] = mk(0, 1, 'h1,   0, 0, 0,     0,           0,   1, 0);
        tbl[11] = mk(0, 0, 0,     1, 0, 'h2,   0,           0,   0, 1);
        tbl[12] = mk(0, 1, 'h3,   0, 0, 0,     0,           0,   1, 0);
        tbl[13] = mk(0, 0, 0,     1, 0, 'h4,   0,           0,   0, 1);
        tbl[14] = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[15] = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[16] = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[17] = mk(0, 1, 'h30,  0, 0, 0,     0,           0,   1, 0);
        tbl[18] = mk(1, 1, 'h30,  1, 1, 'h33,  'hDEAD,      'hF, 0, 0);
        tbl[19] = mk(1, 0, 0,     0, 0, 0,     0,           0,   0, 0);
        tbl[20] = mk(0, 1, 'h31,  0, 0, 0,     0,           0,   1, 0);
        tbl[21] = mk(0, 1, 'h40,  1, 0, 'h41,  0,           0,   1, 0);
        tbl[22] = mk(0, 0, 0,     0, 0, 0,     0,           0,   0, 0);

        @(posedge clock);
        #1;

        for (int i = 0; i < 23; i++) begin
            do_cycle(tbl[i], $sformatf("tbl%0d", i));
        end

        // Both requesters valid continuously: CPU forced in at 8 and 17.
        for (int i = 0; i < 18; i++) begin
            do_cycle(mk(0, 1, 'h200 + i, 1, 0, 'h100, 0, 0,
                        !(i == 8 || i == 17), (i == 8 || i == 17)),
                     $sformatf("starve%0d", i));
        end

        // CPU refused 5 cycles, drops for one, then must wait a full 8 again.
        for (int i = 0; i < 15; i++) begin
            do_cycle(mk(0, 1, 'h300 + i, (i != 5), 0, 'h101, 0, 0,
                        (i != 14), (i == 14)),
                     $sformatf("restart%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("drain%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
